// File: rtl/integer_lane.sv
// Single-issue integer ALU lane with one registered result stage.
// Results are tagged with their ROB index and released on a valid/ready handshake.
module integer_lane #(
  parameter int XLEN                = 32,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           dispatch_ready,
  input  logic                           dispatch_valid,
  input  logic [XLEN-1:0]                dispatch_1st_reg,
  input  logic [XLEN-1:0]                dispatch_2nd_reg,
  input  logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction,
  input  logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index,
  input  logic [XLEN-1:0]                dispatch_PC_i,
  input  logic                           execute_ready,
  output logic                           execute_valid,
  output logic [ROB_INDEX_WIDTH-1:0]     execute_ROB_index,
  output logic [XLEN-1:0]                execute_value,
  input  logic                           flush
);

  localparam int SHW = $clog2(XLEN);
  localparam int OPW = DECODED_INSTR_WIDTH;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(1);
  localparam logic [OPW-1:0] OP_LINK  = OPW'(2);
  localparam logic [OPW-1:0] OP_PASS  = OPW'(3);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(5);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(7);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(8);
  localparam logic [OPW-1:0] OP_OR    = OPW'(9);
  localparam logic [OPW-1:0] OP_AND   = OPW'(10);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(11);
  localparam logic [OPW-1:0] OP_EQ    = OPW'(12);
  localparam logic [OPW-1:0] OP_NE    = OPW'(13);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(14);

  logic            dispatch_fire;
  logic            execute_fire;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            equal;
  logic [XLEN-1:0] alu_result;

  assign dispatch_ready =
    (!execute_valid || execute_ready) && !flush;
  assign dispatch_fire = dispatch_valid && dispatch_ready;
  assign execute_fire  = execute_valid && execute_ready;

  assign op_a  = dispatch_1st_reg;
  assign op_b  = dispatch_2nd_reg;
  assign shamt = op_b[SHW-1:0];

  assign lt_signed   = $signed(op_a) < $signed(op_b);
  assign lt_unsigned = op_a < op_b;
  assign equal       = op_a == op_b;

  always_comb begin
    alu_result = '0;
    case (dispatch_decoded_instruction)
      OP_ADD:   alu_result = op_a + op_b;
      OP_AUIPC: alu_result = dispatch_PC_i + op_b;
      OP_LINK:  alu_result = dispatch_PC_i + XLEN'(4);
      OP_PASS:  alu_result = op_b;
      OP_SLL:   alu_result = op_a << shamt;
      OP_SLT:   alu_result = XLEN'(lt_signed);
      OP_SLTU:  alu_result = XLEN'(lt_unsigned);
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_SRL:   alu_result = op_a >> shamt;
      OP_OR:    alu_result = op_a | op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
      OP_EQ:    alu_result = XLEN'(equal);
      OP_NE:    alu_result = XLEN'(!equal);
      OP_SUB:   alu_result = op_a - op_b;
      default:  alu_result = '0;
    endcase
  end

  // Flush wins over everything; dispatch wins over a plain drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      execute_valid     <= 1'b0;
      execute_ROB_index <= '0;
      execute_value     <= '0;
    end else if (flush) begin
      execute_valid <= 1'b0;
    end else if (dispatch_fire) begin
      execute_valid     <= 1'b1;
      execute_ROB_index <= dispatch_ROB_index;
      execute_value     <= alu_result;
    end else if (execute_fire) begin
      execute_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integer_lane.sv
// Directed bench for integer_lane: behavioural reference model,
// per-cycle comparison, tag-order scoreboard and literal expectations.
module tb_integer_lane;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_ready;
  logic        dispatch_valid;
  logic [31:0] dispatch_1st_reg;
  logic [31:0] dispatch_2nd_reg;
  logic [7:0]  dispatch_decoded_instruction;
  logic [7:0]  dispatch_ROB_index;
  logic [31:0] dispatch_PC_i;
  logic        execute_ready;
  logic        execute_valid;
  logic [7:0]  execute_ROB_index;
  logic [31:0] execute_value;
  logic        flush;

  int errors = 0;
  int checks = 0;

  integer_lane #(
    .XLEN(32),
    .ROB_INDEX_WIDTH(8),
    .DECODED_INSTR_WIDTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dispatch_ready(dispatch_ready),
    .dispatch_valid(dispatch_valid),
    .dispatch_1st_reg(dispatch_1st_reg),
    .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_decoded_instruction(dispatch_decoded_instruction),
    .dispatch_ROB_index(dispatch_ROB_index),
    .dispatch_PC_i(dispatch_PC_i),
    .execute_ready(execute_ready),
    .execute_valid(execute_valid),
    .execute_ROB_index(execute_ROB_index),
    .execute_value(execute_value),
    .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input int op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] pc);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      0:  return 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
      1:  return 32'(longint'(pc) + longint'(b));
      2:  return 32'(longint'(pc) + 4);
      3:  return b;
      4:  return 32'(longint'(a) * (64'd1 << sh));
      5:  return (sa < sb) ? 32'd1 : 32'd0;
      6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      7:  return a ^ b;
      8:  return 32'(longint'(a) / (64'd1 << sh));
      9:  return a | b;
      10: return a & b;
      11: return 32'(sa >>> sh);
      12: return (a == b) ? 32'd1 : 32'd0;
      13: return (a != b) ? 32'd1 : 32'd0;
      14: return 32'(longint'(a) - longint'(b) + (64'd1 << 32));
      default: return 32'd0;
    endcase
  endfunction

  // Reference model state and scoreboard of tags owed to the consumer
  logic        m_valid;
  logic [7:0]  m_tag;
  logic [31:0] m_val;
  logic [7:0]  owed[$];

  function automatic logic m_ready();
    return (!m_valid || execute_ready) && !flush;
  endfunction

  always @(posedge clock or posedge reset) begin
    logic d_hs, e_hs;
    if (reset) begin
      m_valid = 1'b0;
      m_tag   = '0;
      m_val   = '0;
      owed.delete();
    end else begin
      if (execute_valid && execute_ready) begin
        if (owed.size() == 0)
          check("spurious_handshake", {56'd0, execute_ROB_index}, 64'hFFFF);
        else
          check("handshake_tag", {56'd0, execute_ROB_index},
                {56'd0, owed.pop_front()});
      end
      d_hs = dispatch_valid && m_ready();
      e_hs = m_valid && execute_ready;
      if (flush) begin
        m_valid = 1'b0;
        owed.delete();
      end else if (d_hs) begin
        m_valid = 1'b1;
        m_tag   = dispatch_ROB_index;
        m_val   = ref_alu(int'(dispatch_decoded_instruction),
                          dispatch_1st_reg, dispatch_2nd_reg,
                          dispatch_PC_i);
        owed.push_back(dispatch_ROB_index);
      end else if (e_hs) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("ready", {63'd0, dispatch_ready}, {63'd0, m_ready()});
      check("valid", {63'd0, execute_valid}, {63'd0, m_valid});
      if (m_valid) begin
        check("tag", {56'd0, execute_ROB_index}, {56'd0, m_tag});
        check("value", {32'd0, execute_value}, {32'd0, m_val});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc,
                      input logic [7:0] tag);
    dispatch_valid               = 1'b1;
    dispatch_decoded_instruction = 8'(op);
    dispatch_1st_reg             = a;
    dispatch_2nd_reg             = b;
    dispatch_PC_i                = pc;
    dispatch_ROB_index           = tag;
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17] = '{
    '{1,   32'h0,        32'h20,       32'h1000,     32'h1020},
    '{2,   32'h0,        32'h0,        32'hFFFFFFFE, 32'h2},
    '{3,   32'h5,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF},
    '{4,   32'h1,        32'd33,       32'h0,        32'h2},
    '{5,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h1},
    '{6,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0},
    '{7,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0},
    '{8,   32'h80000000, 32'd31,       32'h0,        32'h1},
    '{9,   32'h0F,       32'hF0,       32'h0,        32'hFF},
    '{10,  32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0F000F00},
    '{11,  32'h80000000, 32'd4,        32'h0,        32'hF8000000},
    '{12,  32'h5,        32'h5,        32'h0,        32'h1},
    '{13,  32'h5,        32'h5,        32'h0,        32'h0},
    '{14,  32'h0,        32'h1,        32'h0,        32'hFFFFFFFF},
    '{0,   32'hFFFFFFFF, 32'h2,        32'h0,        32'h1},
    '{15,  32'h1234,     32'h5678,     32'h9,        32'h0},
    '{200, 32'h1234,     32'h5678,     32'h9,        32'h0}
  };

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    execute_ready = 1'b0;
    dispatch_valid = 1'b0;
    send(0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    #3;
    check("rst_valid", {63'd0, execute_valid}, 64'd0);
    check("rst_tag", {56'd0, execute_ROB_index}, 64'd0);
    check("rst_value", {32'd0, execute_value}, 64'd0);
    #9 reset = 1'b0;
    tick();
    #4;
    check("post_rst_ready", {63'd0, dispatch_ready}, 64'd1);
    check("post_rst_valid", {63'd0, execute_valid}, 64'd0);

    // Held result stalls with consumer not ready
    tick();
    send(0, 17, 18, 0, 11);
    tick();
    dispatch_valid = 1'b0;
    #4;
    check("add_valid", {63'd0, execute_valid}, 64'd1);
    check("add_value", {32'd0, execute_value}, 64'd35);
    check("add_tag", {56'd0, execute_ROB_index}, 64'd11);
    check("stall_ready", {63'd0, dispatch_ready}, 64'd0);
    tick();
    tick();
    #4;
    check("hold_value", {32'd0, execute_value}, 64'd35);
    check("hold_tag", {56'd0, execute_ROB_index}, 64'd11);
    execute_ready = 1'b1;
    #1;
    check("drain_ready", {63'd0, dispatch_ready}, 64'd1);
    tick();
    #4;
    check("drained_valid", {63'd0, execute_valid}, 64'd0);

    // SUB then OR back to back
    tick();
    send(14, 7, 6, 0, 12);
    tick();
    send(9, 7, 8, 0, 13);
    #4;
    check("sub_value", {32'd0, execute_value}, 64'd1);
    check("sub_tag", {56'd0, execute_ROB_index}, 64'd12);
    tick();
    dispatch_valid = 1'b0;
    #4;
    check("or_value", {32'd0, execute_value}, 64'd15);
    check("or_tag", {56'd0, execute_ROB_index}, 64'd13);
    tick();

    // Full-throughput stream over every opcode
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, 8'(40 + i));
      tick();
      #4;
      check($sformatf("vec%0d_value", i),
            {32'd0, execute_value}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d_tag", i),
            {56'd0, execute_ROB_index}, 64'(40 + i));
      #0;
    end
    dispatch_valid = 1'b0;
    tick();

    // Flush discards a held result and blocks a concurrent dispatch
    execute_ready = 1'b0;
    send(0, 1, 2, 0, 20);
    tick();
    dispatch_valid = 1'b0;
    tick();
    flush = 1'b1;
    send(0, 3, 4, 0, 21);
    #4;
    check("flush_ready", {63'd0, dispatch_ready}, 64'd0);
    tick();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    #4;
    check("flush_valid", {63'd0, execute_valid}, 64'd0);
    execute_ready = 1'b1;
    tick();
    tick();

    // Asynchronous reset drops a held result
    execute_ready = 1'b0;
    send(3, 0, 32'hCAFE, 0, 30);
    tick();
    dispatch_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, execute_valid}, 64'd0);
    check("arst_tag", {56'd0, execute_ROB_index}, 64'd0);
    check("arst_value", {32'd0, execute_value}, 64'd0);
    execute_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    #4;
    check("arst_ready", {63'd0, dispatch_ready}, 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_lane.md
INTEGER_LANE -- requirements
Module: integer_lane

Interface
REQ-001 Parameter XLEN, default 32, operand/result/PC width.
REQ-002 Parameter ROB_INDEX_WIDTH, default 8, ROB tag width.
REQ-003 Parameter DECODED_INSTR_WIDTH, default 8, opcode width.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dispatch_ready  output  1  lane can accept an instruction this cycle.
REQ-007 dispatch_valid  input  1  dispatch offers an instruction.
REQ-008 dispatch_1st_reg  input  XLEN  operand A.
REQ-009 dispatch_2nd_reg  input  XLEN  operand B.
REQ-010 dispatch_decoded_instruction  input  DECODED_INSTR_WIDTH  ALU opcode.
REQ-011 dispatch_ROB_index  input  ROB_INDEX_WIDTH  destination ROB tag.
REQ-012 dispatch_PC_i  input  XLEN  instruction PC.
REQ-013 execute_ready  input  1  consumer accepts the result.
REQ-014 execute_valid  output  1  result register holds a valid result.
REQ-015 execute_ROB_index  output  ROB_INDEX_WIDTH  tag of held result.
REQ-016 execute_value  output  XLEN  held result.
REQ-017 flush  input  1  pipeline flush.

Function
REQ-018 The lane SHALL contain one output register stage (valid, ROB tag, value); latency from dispatch handshake to execute_valid is exactly 1 clock.
REQ-019 dispatch_ready SHALL equal (!execute_valid || execute_ready) && !flush, combinationally.
REQ-020 Dispatch handshake = dispatch_valid && dispatch_ready; on it the register SHALL load valid=1, tag=dispatch_ROB_index, value=ALU result.
REQ-021 Execute handshake = execute_valid && execute_ready; if no dispatch handshake in the same cycle, valid SHALL clear to 0.
REQ-022 Simultaneous execute and dispatch handshakes SHALL replace the held result with the new one (full throughput, one result per cycle).
REQ-023 With execute_valid=1 and execute_ready=0, tag and value SHALL hold stable until accepted.
REQ-024 flush=1 SHALL clear valid at the next edge, discard any held result, and block dispatch that cycle; tag/value contents are don't-care.
REQ-025 Opcodes (A=1st_reg, B=2nd_reg, shift amount = B[log2(XLEN)-1:0]): 0 ADD A+B; 1 AUIPC PC+B; 2 LINK PC+4; 3 PASS B; 4 SLL; 5 SLT signed (1/0); 6 SLTU (1/0); 7 XOR; 8 SRL; 9 OR; 10 AND; 11 SRA; 12 EQ (1/0); 13 NE (1/0); 14 SUB A-B; any other opcode result 0.
REQ-026 Arithmetic SHALL be modulo 2^XLEN (wrap-around, no overflow flag); comparisons zero-extended to XLEN.
REQ-027 The ALU SHALL be combinational from dispatch inputs; no operand is stored other than the result.

Reset
REQ-028 While reset=1 (asynchronously): execute_valid=0, execute_ROB_index=0, execute_value=0.
REQ-029 After reset deasserts with flush=0, dispatch_ready SHALL be 1.
REQ-030 Reset mid-operation SHALL discard any held result without it appearing on the execute handshake.

Verification
REQ-031 Reset 10 time units, release -> dispatch_ready=1, execute_valid=0.
REQ-032 Dispatch op 0, A=17, B=18, tag 11, execute_ready=0 -> next cycle execute_valid=1, value 35, tag 11, dispatch_ready=0, held stable for multiple cycles.
REQ-033 Raise execute_ready -> result 35/tag 11 consumed in one cycle, execute_valid=0, dispatch_ready=1.
REQ-034 execute_ready=1, dispatch op 14, A=7, B=6, tag 12 -> value 1, tag 12; then op 9, A=7, B=8, tag 13 -> value 15, tag 13.
REQ-035 Back-to-back dispatches with execute_ready=1 -> one result per cycle, tags in order, no loss or duplication.
REQ-036 Held result with flush=1 for one cycle -> execute_valid=0 next cycle, result never handshaken, dispatch_ready=0 during flush.
